// File: rtl/stream_buffer_pkg.sv
// Shared widths and defaults for the stream buffer slice.
package stream_buffer_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 32;
  localparam int unsigned MEM_DATA_WIDTH = 256;
  localparam int unsigned STREAM_DEPTH   = 16;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO, DW x DEPTH, with occupancy count and async active-low reset.
module stream_fifo #(
  parameter int unsigned DW    = 256,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array write; contents need no reset since count gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/stream_buffer.sv
// Fetches [stream_base, stream_end) from memory and streams the words out in order.
module stream_buffer
  import stream_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = STREAM_DEPTH,
  parameter int unsigned AW    = MEM_ADDR_WIDTH,
  parameter int unsigned DW    = MEM_DATA_WIDTH
) (
  input  logic          eclk,
  input  logic          rstb,
  input  logic          stream_start,
  input  logic [AW-1:0] stream_base,
  input  logic [AW-1:0] stream_end,
  input  logic          memc_cmd_full,
  output logic          rcmd_valid,
  output logic [AW-1:0] rcmd_addr,
  input  logic          rdata_valid,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] bdata,
  output logic          bvalid,
  input  logic          bstall,
  output logic          stream_empty,
  output logic          collision_stream_done,
  output logic          rsp_err
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t        state;
  logic [AW-1:0] nxt_addr;
  logic [AW-1:0] end_addr;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] fifo_head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          issue;
  logic          accept;
  logic          pop;

  // Credits cover both buffered entries and reads still in flight.
  assign issue  = (state == FETCH) && !memc_cmd_full && (nxt_addr != end_addr) &&
                  (({1'b0, fifo_count} + {1'b0, outstanding}) < (CW+1)'(DEPTH));
  assign accept = rdata_valid && (outstanding != '0);
  assign pop    = !bstall && !fifo_empty;

  assign rcmd_valid   = issue;
  assign rcmd_addr    = nxt_addr;
  assign stream_empty = fifo_empty && (outstanding == '0) && !bvalid;

  stream_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (eclk),
    .rst_n     (rstb),
    .push      (accept),
    .push_data (rdata),
    .pop       (pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Stream control: address walk, drain detection and the registered done flag.
  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      state                 <= IDLE;
      nxt_addr              <= '0;
      end_addr              <= '0;
      collision_stream_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (stream_start) begin
            nxt_addr              <= stream_base;
            // A reversed range collapses to an empty stream.
            end_addr              <= (stream_end < stream_base) ? stream_base : stream_end;
            collision_stream_done <= 1'b0;
            state                 <= FETCH;
          end
        end
        FETCH: begin
          if (issue) nxt_addr <= nxt_addr + AW'(1);
          if (nxt_addr == end_addr) state <= DRAIN;
        end
        DRAIN: begin
          if ((outstanding == '0) && fifo_empty && !bvalid) begin
            state                 <= DONE;
            collision_stream_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads in flight; stray returns with nothing outstanding raise the sticky error.
  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      outstanding <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case ({issue, accept})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      if (rdata_valid && (outstanding == '0)) rsp_err <= 1'b1;
    end
  end

  // Registered output beat; bdata holds between beats.
  always_ff @(posedge eclk or negedge rstb) begin
    if (!rstb) begin
      bvalid <= 1'b0;
      bdata  <= '0;
    end else begin
      bvalid <= pop;
      if (pop) bdata <= fifo_head;
    end
  end

endmodule

// File: tb/tb_stream_buffer.sv
// Randomised scoreboard bench for stream_buffer with an in-order memory responder.
module tb_stream_buffer;

  localparam int AW    = 32;
  localparam int DW    = 256;
  localparam int DEPTH = 16;

  logic          eclk = 1'b0;
  logic          rstb = 1'b0;
  logic          stream_start = 1'b0;
  logic [AW-1:0] stream_base = '0;
  logic [AW-1:0] stream_end = '0;
  logic          memc_cmd_full = 1'b0;
  logic          rcmd_valid;
  logic [AW-1:0] rcmd_addr;
  logic          rdata_valid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] bdata;
  logic          bvalid;
  logic          bstall;
  logic          stream_empty;
  logic          collision_stream_done;
  logic          rsp_err;

  // bench control
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   lat = 3;          // 0 selects a random latency per read
  int   full_mode = 0;    // 0 off, 1 toggle 1-on/2-off, 2 block after 5 issues, 3 random
  int   stall_mode = 0;   // 0 off, 1 held high, 2 random, 3 pulse on every beat
  logic stall_hold = 1'b0;
  int   n_issue = 0;
  int   n_beat = 0;
  int   last_bv_cyc = 0;
  int   last_due = 0;
  logic prev_bv = 1'b0;
  int   start_cyc = 0;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;

  pend_t         pend[$];
  logic [AW-1:0] exp_addr[$];
  logic [DW-1:0] exp_data[$];
  int            iss_cyc[$];
  int            bv_cyc[$];

  assign bstall = (stall_mode == 3) ? bvalid : stall_hold;

  stream_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) dut (
    .eclk                  (eclk),
    .rstb                  (rstb),
    .stream_start          (stream_start),
    .stream_base           (stream_base),
    .stream_end            (stream_end),
    .memc_cmd_full         (memc_cmd_full),
    .rcmd_valid            (rcmd_valid),
    .rcmd_addr             (rcmd_addr),
    .rdata_valid           (rdata_valid),
    .rdata                 (rdata),
    .bdata                 (bdata),
    .bvalid                (bvalid),
    .bstall                (bstall),
    .stream_empty          (stream_empty),
    .collision_stream_done (collision_stream_done),
    .rsp_err               (rsp_err)
  );

  always #5 eclk = ~eclk;

  function automatic logic [DW-1:0] data_of(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < 8; k++) d[32*k +: 32] = a ^ (32'h1357_9BDF * (k + 1));
    return d;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Cycle counter, memory responder and per-cycle input shaping.
  initial begin
    forever begin
      @(posedge eclk);
      cyc++;
      #1;
      if (rstb && pend.size() > 0 && pend[0].due <= cyc) begin
        rdata_valid = 1'b1;
        rdata       = data_of(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        rdata_valid = 1'b0;
      end
      case (full_mode)
        1:       memc_cmd_full = (cyc % 3 == 0);
        2:       memc_cmd_full = (n_issue >= 5);
        3:       memc_cmd_full = ($urandom_range(0, 3) == 0);
        default: memc_cmd_full = 1'b0;
      endcase
      case (stall_mode)
        1:       stall_hold = 1'b1;
        2:       stall_hold = ($urandom_range(0, 2) == 0);
        default: stall_hold = 1'b0;
      endcase
    end
  end

  // Monitor: checks commands and beats against the expected queues.
  initial begin
    forever begin
      @(negedge eclk);
      if (rstb) begin
        if (rcmd_valid) begin
          int d;
          chk("cmd_while_full", memc_cmd_full, 1'b0);
          if (exp_addr.size() == 0) begin
            chk("cmd_unexpected", 1'b1, 1'b0);
          end else begin
            chk("cmd_addr", rcmd_addr, exp_addr.pop_front());
          end
          d = cyc + ((lat == 0) ? $urandom_range(2, 6) : lat);
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          pend.push_back('{addr: rcmd_addr, due: d});
          iss_cyc.push_back(cyc);
          n_issue++;
        end
        if (bvalid) begin
          if (exp_data.size() == 0) begin
            chk("beat_unexpected", 1'b1, 1'b0);
          end else begin
            chk("beat_data", bdata, exp_data.pop_front());
          end
          if (stall_mode == 3) chk("beat_back_to_back", prev_bv, 1'b0);
          bv_cyc.push_back(cyc);
          last_bv_cyc = cyc;
          n_beat++;
        end
        prev_bv = bvalid;
      end
    end
  end

  task automatic start_stream(input logic [AW-1:0] b, input logic [AW-1:0] e);
    @(posedge eclk);
    #2;
    stream_base  = b;
    stream_end   = e;
    stream_start = 1'b1;
    n_issue      = 0;
    iss_cyc.delete();
    bv_cyc.delete();
    start_cyc = cyc;
    if (e > b) begin
      for (longint unsigned i = 0; i < longint'(e - b); i++) begin
        exp_addr.push_back(b + AW'(i));
        exp_data.push_back(data_of(b + AW'(i)));
      end
    end
    @(posedge eclk);
    #2;
    stream_start = 1'b0;
    @(negedge eclk);
    chk("done_cleared", collision_stream_done, 1'b0);
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge eclk);
      if (collision_stream_done) begin
        dcyc = cyc;
        break;
      end
    end
    chk("done_timeout", (dcyc >= 0), 1'b1);
    chk("addr_left", exp_addr.size(), 0);
    chk("beats_left", exp_data.size(), 0);
    chk("empty_at_done", stream_empty, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    int beats_before;
    // reset state
    repeat (3) @(negedge eclk);
    chk("rst_rcmd_valid", rcmd_valid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_empty", stream_empty, 1'b1);
    chk("rst_done", collision_stream_done, 1'b0);
    chk("rst_err", rsp_err, 1'b0);
    #2;
    rstb = 1'b1;
    repeat (2) @(negedge eclk);

    // basic 4-word stream, fixed latency 3
    lat = 3;
    start_stream(32'h100, 32'h104);
    wait_done(dc);
    chk("t1_issues", iss_cyc.size(), 4);
    chk("t1_beats", bv_cyc.size(), 4);
    for (int i = 1; i < iss_cyc.size(); i++) chk("t1_issue_consec", iss_cyc[i] - iss_cyc[0], i);
    for (int i = 1; i < bv_cyc.size(); i++) chk("t1_beat_consec", bv_cyc[i] - bv_cyc[0], i);
    chk("t1_done_delay", dc - last_bv_cyc, 2);

    // credit limit under held back-pressure
    lat = 0;
    stall_mode = 1;
    start_stream(32'h1000, 32'h1000 + 40);
    repeat (80) @(negedge eclk);
    chk("t2_issue_cap", n_issue, DEPTH);
    chk("t2_no_beat", bv_cyc.size(), 0);
    stall_mode = 0;
    wait_done(dc);
    chk("t2_issues", n_issue, 40);
    chk("t2_beats", bv_cyc.size(), 40);

    // command queue full toggling
    full_mode = 1;
    start_stream(32'h2000, 32'h200A);
    wait_done(dc);
    chk("t3_issues", n_issue, 10);
    full_mode = 0;

    // one-cycle stall after every beat
    stall_mode = 3;
    start_stream(32'h3000, 32'h3000 + 12);
    wait_done(dc);
    chk("t4_beats", bv_cyc.size(), 12);
    stall_mode = 0;

    // empty stream
    start_stream(32'h40, 32'h40);
    @(negedge eclk);
    chk("t5_done_early", collision_stream_done, 1'b0);
    chk("t5_empty_a", stream_empty, 1'b1);
    @(negedge eclk);
    chk("t5_done_at3", collision_stream_done, 1'b1);
    chk("t5_empty_b", stream_empty, 1'b1);
    chk("t5_issues", n_issue, 0);

    // randomised streams including a reversed range
    lat = 0;
    for (int s = 0; s < 6; s++) begin
      logic [AW-1:0] b;
      logic [AW-1:0] e;
      b = $urandom_range(0, 32'h00FF_FFFF);
      e = (s == 3) ? b - 5 : b + AW'($urandom_range(0, 30));
      full_mode  = 3;
      stall_mode = 2;
      start_stream(b, e);
      wait_done(dc);
      chk("rand_issues", n_issue, (e > b) ? int'(e - b) : 0);
    end
    full_mode  = 0;
    stall_mode = 0;

    // reset mid-stream with reads in flight, stale returns afterwards
    chk("t6_err_clean", rsp_err, 1'b0);
    lat = 20;
    full_mode = 2;
    start_stream(32'h5000, 32'h5020);
    repeat (6) @(negedge eclk);
    chk("t6_inflight", n_issue, 5);
    #2;
    rstb = 1'b0;
    #1;
    chk("t6_rst_rcmd", rcmd_valid, 1'b0);
    chk("t6_rst_bvalid", bvalid, 1'b0);
    chk("t6_rst_empty", stream_empty, 1'b1);
    chk("t6_rst_done", collision_stream_done, 1'b0);
    chk("t6_rst_err", rsp_err, 1'b0);
    exp_addr.delete();
    exp_data.delete();
    full_mode = 0;
    repeat (3) @(negedge eclk);
    #2;
    rstb = 1'b1;
    beats_before = n_beat;
    for (int i = 0; i < 100 && pend.size() > 0; i++) @(negedge eclk);
    chk("t6_stale_drained", pend.size(), 0);
    repeat (3) @(negedge eclk);
    chk("t6_err_set", rsp_err, 1'b1);
    chk("t6_empty", stream_empty, 1'b1);
    chk("t6_no_beats", n_beat - beats_before, 0);
    chk("t6_done_low", collision_stream_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
